cordic_vector_rtl: RTL and testbench

- Vectoring-mode CORDIC: the inverse of the sin/cos rotation block.
- Takes a Cartesian pair (x_in, y_in) in signed Q2.10 and returns the phase atan2(y, x) and the gain-compensated magnitude sqrt(x²+y²).
- Iterative: one micro-rotation per clock. Uses the same start/ready_out handshake and Q2.10 fixed-point convention as the rotation block, so the two can be chained back-to-back in the datapath.

---
 rtl/cordic_vector_rtl.sv | 161 ++++++++++++++++
 tb/tb_cordic_vector_rtl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_rtl.sv
// Iterative vectoring-mode CORDIC: (x, y) in Q2.10 -> atan2(y, x) and gain-compensated magnitude.
// One micro-rotation per clock; results are registered in a final SCALE cycle and held.
module cordic_vector_rtl #(
    parameter int ITER = 12,
    parameter int IW   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    output logic        ready_out,
    output logic        busy_out,
    output logic [11:0] angle_out,
    output logic [11:0] mag_out,
    output logic        err_out
);

    typedef enum logic [1:0] {IDLE, CALC, SCALE} state_t;

    state_t               state_q, state_d;
    logic                 start_q;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [3:0]           iter_q, iter_d;
    logic                 neg_q, neg_d, zero_q, zero_d;
    logic                 ready_q, ready_d, busy_q, busy_d, err_q, err_d;
    logic [11:0]          angle_q, angle_d, mag_q, mag_d;

    logic                 accept;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [31:0]   prod, mag_rnd;
    logic [11:0]          mag_sat;

    // round(atan(2^-i) * 4096)
    function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return IW'(3217);
            4'd1:    return IW'(1899);
            4'd2:    return IW'(1003);
            4'd3:    return IW'(509);
            4'd4:    return IW'(256);
            4'd5:    return IW'(128);
            4'd6:    return IW'(64);
            4'd7:    return IW'(32);
            4'd8:    return IW'(16);
            4'd9:    return IW'(8);
            4'd10:   return IW'(4);
            4'd11:   return IW'(2);
            4'd12:   return IW'(1);
            default: return '0;
        endcase
    endfunction

    assign accept = start & ~start_q & (state_q == IDLE);
    assign x_sh   = x_q >>> iter_q;
    assign y_sh   = y_q >>> iter_q;

    // 2487/4096 ~= 1/1.64676 removes the CORDIC gain; then round Q.12 back to Q.10
    assign prod    = 32'(x_q) * 32'sd2487;
    assign mag_rnd = ((prod >>> 12) + 32'sd2) >>> 2;
    assign mag_sat = mag_rnd[31] ? 12'd0 :
                     (mag_rnd > 32'sd4095) ? 12'hFFF : mag_rnd[11:0];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    x_d     = {{(IW-14){x_in[11]}}, x_in, 2'b00};
                    y_d     = {{(IW-14){y_in[11]}}, y_in, 2'b00};
                    z_d     = '0;
                    iter_d  = 4'd0;
                    neg_d   = x_in[11];
                    zero_d  = (x_in == 12'd0) && (y_in == 12'd0);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // drive y toward zero; z accumulates the angle rotated away
                if (!y_q[IW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(iter_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(iter_q);
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITER-1))
                    state_d = SCALE;
            end
            SCALE: begin
                ready_d = 1'b1;
                state_d = IDLE;
                if (neg_q || zero_q) begin
                    angle_d = 12'd0;
                    mag_d   = 12'd0;
                    err_d   = neg_q;
                end else begin
                    angle_d = 12'((z_q + IW'(2)) >>> 2);
                    mag_d   = mag_sat;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= 4'd0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            angle_q <= 12'd0;
            mag_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign angle_out = angle_q;
    assign mag_out   = mag_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_cordic_vector_rtl.sv
// Bench for cordic_vector_rtl: directed corner cases plus random vectors checked
// against ideal atan2/sqrt with the stated accuracy bounds.
module tb_cordic_vector_rtl;

    localparam real PI = 3.14159265358979;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [11:0] x_in  = '0;
    logic signed [11:0] y_in  = '0;
    logic               ready_out, busy_out, err_out;
    logic [11:0]        angle_out, mag_out;

    int n_chk   = 0;
    int n_err   = 0;
    int rdy_cnt = 0;

    cordic_vector_rtl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .ready_out (ready_out),
        .busy_out  (busy_out),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .err_out   (err_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (ready_out) rdy_cnt++;
    end

    task automatic chk(input string tag, input int obs, input real exp, input real tol);
        real d;
        n_chk++;
        d = real'(obs) - exp;
        if (d < 0.0) d = -d;
        if (d > tol + 1e-6) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0.2f (+/-%0.1f)", tag, obs, exp, tol);
        end
    endtask

    // Ideal results: atan2 in Q2.10 radians, Euclidean length in Q2.10
    task automatic check_res(input int x, input int y);
        real ea, em;
        if (x < 0) begin
            chk("err_neg", int'(err_out), 1.0, 0.0);
            chk("ang_neg", int'($signed(angle_out)), 0.0, 0.0);
            chk("mag_neg", int'(mag_out), 0.0, 0.0);
        end else if (x == 0 && y == 0) begin
            chk("err_zero", int'(err_out), 0.0, 0.0);
            chk("ang_zero", int'($signed(angle_out)), 0.0, 0.0);
            chk("mag_zero", int'(mag_out), 0.0, 0.0);
        end else begin
            ea = $atan2(real'(y), real'(x)) * 1024.0;
            em = $sqrt(real'(x * x + y * y));
            chk("err", int'(err_out), 0.0, 0.0);
            chk("angle", int'($signed(angle_out)), ea, 2.0);
            chk("mag", int'(mag_out), em, 4.0);
        end
    endtask

    // Caller is at a negedge; drives operands and waits (bounded) for ready_out.
    task automatic run_op(input int x, input int y, input int hold, output int lat);
        x_in  = 12'(x);
        y_in  = 12'(y);
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == hold) start = 1'b0;
            if (k == 1) chk("busy_on", int'(busy_out), 1.0, 0.0);
            if (ready_out) begin
                lat = k - 1;
                chk("busy_at_rdy", int'(busy_out), 1.0, 0.0);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic op_chk(input int x, input int y, input int hold);
        int lat, c0;
        @(negedge clock);
        c0 = rdy_cnt;
        run_op(x, y, hold, lat);
        chk("latency", lat, 13.0, 0.0);
        check_res(x, y);
        @(negedge clock);
        chk("rdy_drop", int'(ready_out), 0.0, 0.0);
        chk("busy_drop", int'(busy_out), 0.0, 0.0);
        repeat (3) @(negedge clock);
        chk("one_pulse", rdy_cnt - c0, 1.0, 0.0);
        check_res(x, y);
    endtask

    initial begin
        int lat, c0, x, y, r;
        real th;

        repeat (2) @(negedge clock);
        chk("rst_rdy", int'(ready_out), 0.0, 0.0);
        chk("rst_busy", int'(busy_out), 0.0, 0.0);
        chk("rst_ang", int'(angle_out), 0.0, 0.0);
        chk("rst_mag", int'(mag_out), 0.0, 0.0);
        chk("rst_err", int'(err_out), 0.0, 0.0);
        reset = 1'b0;

        op_chk(783, 660, 3);
        op_chk(1024, 0, 1);
        op_chk(0, 1024, 1);
        op_chk(0, -1024, 1);
        op_chk(2047, 2047, 1);
        op_chk(2047, -2048, 1);
        op_chk(-512, 100, 1);
        op_chk(0, 0, 1);

        // second start edge mid-run must be dropped, not queued
        @(negedge clock);
        c0    = rdy_cnt;
        x_in  = 12'sd500;
        y_in  = 12'sd300;
        start = 1'b1;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (k == 4) begin
                start = 1'b1;
                x_in  = -12'sd700;
                y_in  = -12'sd5;
            end
            if (k == 5) start = 1'b0;
            if (ready_out) begin
                lat = k - 1;
                break;
            end
        end
        chk("ign_lat", lat, 13.0, 0.0);
        check_res(500, 300);
        // start raised during the ready_out cycle is accepted by the next edge
        run_op(1500, -200, 1, lat);
        chk("b2b_lat", lat, 13.0, 0.0);
        check_res(1500, -200);
        repeat (4) @(negedge clock);
        chk("ign_pulses", rdy_cnt - c0, 2.0, 0.0);

        // reset in the middle of a run
        @(negedge clock);
        c0    = rdy_cnt;
        x_in  = 12'sd900;
        y_in  = 12'sd400;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_rdy", int'(ready_out), 0.0, 0.0);
        chk("mrst_busy", int'(busy_out), 0.0, 0.0);
        chk("mrst_ang", int'(angle_out), 0.0, 0.0);
        chk("mrst_mag", int'(mag_out), 0.0, 0.0);
        chk("mrst_err", int'(err_out), 0.0, 0.0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("mrst_nopulse", rdy_cnt - c0, 0.0, 0.0);
        op_chk(900, 400, 1);

        // random vectors: radius 1.0..2.0, any angle in the right half plane; some x<0
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                x = -int'($urandom_range(1, 2048));
                y = int'($urandom_range(0, 4095)) - 2048;
            end else begin
                r  = 1024 + int'($urandom_range(0, 1000));
                th = (real'($urandom_range(0, 20000)) / 20000.0 - 0.5) * PI;
                x  = int'($rtoi($floor(real'(r) * $cos(th) + 0.5)));
                y  = int'($rtoi($floor(real'(r) * $sin(th) + 0.5)));
                if (x < 0) x = 0;
            end
            op_chk(x, y, int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
